// File: rtl/fp64_result_packer.sv
// Back end of the binary64 Vedic multiplier: normalize, round-to-nearest-even,
// then pack the result with exception flags through a 3-stage stallable pipe.
module fp64_result_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [10:0]  in_exp_a,
    input  logic [10:0]  in_exp_b,
    input  logic [105:0] in_mant_prod,
    input  logic [1:0]   in_class,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_result,
    output logic         out_overflow,
    output logic         out_underflow,
    output logic         out_inexact
);

    localparam int BIAS = 1023;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } cls_e;

    typedef struct packed {
        logic        sign;
        cls_e        cls;
        logic [12:0] exp;
        logic [51:0] frac;
        logic        guard;
        logic        sticky;
    } s1_t;

    typedef struct packed {
        logic        sign;
        cls_e        cls;
        logic [12:0] exp;
        logic [51:0] frac;
        logic        inexact;
    } s2_t;

    logic        adv;

    logic        s1_valid_d, s1_valid_q;
    s1_t         s1_new, s1_d, s1_q;

    logic        s2_valid_d, s2_valid_q;
    s2_t         s2_new, s2_d, s2_q;

    logic        out_valid_d, out_valid_q;
    logic [63:0] out_result_d, out_result_q;
    logic        out_overflow_d, out_overflow_q;
    logic        out_underflow_d, out_underflow_q;
    logic        out_inexact_d, out_inexact_q;

    logic [63:0] pk_result;
    logic        pk_overflow;
    logic        pk_underflow;
    logic        pk_inexact;

    logic        rnd_up;
    logic [52:0] rnd_sum;

    // One global advance: every stage moves together or holds together.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        s1_new      = '0;
        s1_new.sign = in_sign;
        s1_new.cls  = cls_e'(in_class);
        if (in_mant_prod[105]) begin
            s1_new.frac   = in_mant_prod[104:53];
            s1_new.guard  = in_mant_prod[52];
            s1_new.sticky = |in_mant_prod[51:0];
        end else begin
            s1_new.frac   = in_mant_prod[103:52];
            s1_new.guard  = in_mant_prod[51];
            s1_new.sticky = |in_mant_prod[50:0];
        end
        s1_new.exp = {2'b00, in_exp_a}
                   + {2'b00, in_exp_b}
                   - 13'(BIAS)
                   + {12'd0, in_mant_prod[105]};
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_d       = s1_new;
        end
    end

    always_comb begin
        rnd_up         = s1_q.guard && (s1_q.sticky || s1_q.frac[0]);
        rnd_sum        = {1'b0, s1_q.frac} + {52'd0, rnd_up};
        s2_new         = '0;
        s2_new.sign    = s1_q.sign;
        s2_new.cls     = s1_q.cls;
        s2_new.frac    = rnd_sum[51:0];
        s2_new.exp     = s1_q.exp + {12'd0, rnd_sum[52]};
        s2_new.inexact = s1_q.guard || s1_q.sticky;
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_d       = s2_new;
        end
    end

    always_comb begin
        pk_result    = '0;
        pk_overflow  = 1'b0;
        pk_underflow = 1'b0;
        pk_inexact   = 1'b0;
        unique case (s2_q.cls)
            CLS_ZERO: pk_result = {s2_q.sign, 63'd0};
            CLS_INF:  pk_result = {s2_q.sign, 11'h7FF, 52'd0};
            CLS_NAN:  pk_result = QNAN;
            CLS_NORM: begin
                if ($signed(s2_q.exp) >= 13'sd2047) begin
                    pk_result   = {s2_q.sign, 11'h7FF, 52'd0};
                    pk_overflow = 1'b1;
                    pk_inexact  = 1'b1;
                end else if ($signed(s2_q.exp) <= 13'sd0) begin
                    // Subnormal range is flushed, never denormalized.
                    pk_result    = {s2_q.sign, 63'd0};
                    pk_underflow = 1'b1;
                    pk_inexact   = 1'b1;
                end else begin
                    pk_result  = {s2_q.sign, s2_q.exp[10:0], s2_q.frac};
                    pk_inexact = s2_q.inexact;
                end
            end
        endcase
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_overflow_d  = out_overflow_q;
        out_underflow_d = out_underflow_q;
        out_inexact_d   = out_inexact_q;
        if (adv) begin
            out_valid_d     = s2_valid_q;
            out_result_d    = pk_result;
            out_overflow_d  = pk_overflow;
            out_underflow_d = pk_underflow;
            out_inexact_d   = pk_inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_q            <= '0;
            s2_valid_q      <= 1'b0;
            s2_q            <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_inexact_q   <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_q            <= s1_d;
            s2_valid_q      <= s2_valid_d;
            s2_q            <= s2_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_overflow_q  <= out_overflow_d;
            out_underflow_q <= out_underflow_d;
            out_inexact_q   <= out_inexact_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_overflow_q;
    assign out_underflow = out_underflow_q;
    assign out_inexact   = out_inexact_q;

endmodule

// File: tb/tb_fp64_result_packer.sv
// Scoreboard bench for fp64_result_packer: directed IEEE cases, random
// products against a reference model, backpressure and mid-stream reset.
module tb_fp64_result_packer;

    typedef logic [66:0] exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sign = 1'b0;
    logic [10:0]  in_exp_a = '0;
    logic [10:0]  in_exp_b = '0;
    logic [105:0] in_mant_prod = '0;
    logic [1:0]   in_class = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  out_result;
    logic         out_overflow;
    logic         out_underflow;
    logic         out_inexact;

    exp_t sbq[$];
    exp_t drv_exp = '0;
    exp_t held;
    int   n_vec = 0;
    int   n_err = 0;
    logic tog_en = 1'b0;

    always #5 clk = ~clk;

    fp64_result_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp_a     (in_exp_a),
        .in_exp_b     (in_exp_b),
        .in_mant_prod (in_mant_prod),
        .in_class     (in_class),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_inexact  (out_inexact)
    );

    task automatic chk(input string tag, input exp_t got, input exp_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: round on the whole remainder rather than guard/sticky bits.
    function automatic exp_t model(input logic sg, input logic [10:0] ea,
                                   input logic [10:0] eb, input logic [105:0] p,
                                   input logic [1:0] c);
        int           e;
        int           sh;
        logic [53:0]  m;
        logic [105:0] rem;
        logic [105:0] half;
        logic         up;
        logic         inx;
        if (c == 2'b01) return {sg, 63'd0, 3'b000};
        if (c == 2'b10) return {sg, 11'h7FF, 52'd0, 3'b000};
        if (c == 2'b11) return {64'h7FF8_0000_0000_0000, 3'b000};
        sh   = p[105] ? 53 : 52;
        m    = 54'(p >> sh);
        rem  = p & ((106'd1 << sh) - 106'd1);
        half = 106'd1 << (sh - 1);
        e    = int'(ea) + int'(eb) - 1023 + (p[105] ? 1 : 0);
        inx  = (rem != 0);
        up   = (rem > half) || ((rem == half) && m[0]);
        m    = m + 54'(up);
        if (m[53]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 2047) return {sg, 11'h7FF, 52'd0, 3'b101};
        if (e <= 0) return {sg, 63'd0, 3'b011};
        return {sg, 11'(e), m[51:0], 2'b00, inx};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0)
                    chk("sb_spurious_out", exp_t'(out_valid), exp_t'(0));
                else
                    chk("sb_result",
                        {out_result, out_overflow, out_underflow, out_inexact},
                        sbq.pop_front());
            end
            if (in_valid && in_ready) sbq.push_back(drv_exp);
        end
    end

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic sg, input logic [10:0] ea,
                        input logic [10:0] eb, input logic [105:0] p,
                        input logic [1:0] c, input exp_t e);
        in_valid     = 1'b1;
        in_sign      = sg;
        in_exp_a     = ea;
        in_exp_b     = eb;
        in_mant_prod = p;
        in_class     = c;
        drv_exp      = e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", exp_t'(in_ready), exp_t'(1));
        in_valid = 1'b0;
    endtask

    task automatic sendm(input logic sg, input logic [10:0] ea,
                         input logic [10:0] eb, input logic [105:0] p,
                         input logic [1:0] c);
        send(sg, ea, eb, p, c, model(sg, ea, eb, p, c));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_t'(sbq.size()), exp_t'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [105:0] one;
        logic [105:0] carry;
        logic [105:0] tie;
        one   = 106'd1 << 104;
        carry = {2'b01, 52'hF_FFFF_FFFF_FFFF, 1'b1, 51'd0};
        tie   = {2'b01, 52'hF_FFFF_FFFF_FFFE, 1'b1, 51'd0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", exp_t'(out_valid), exp_t'(0));
        chk("rst_outputs",
            {out_result, out_overflow, out_underflow, out_inexact}, exp_t'(0));
        chk("rst_in_ready", exp_t'(in_ready), exp_t'(1));
        @(posedge clk);
        #1;

        send(0, 11'd1023, 11'd1023, one, 2'b00, {64'h3FF0_0000_0000_0000, 3'b000});
        send(0, 11'd1023, 11'd1023, 106'd9 << 102, 2'b00,
             {64'h4002_0000_0000_0000, 3'b000});
        send(0, 11'd1023, 11'd1023, carry, 2'b00, {64'h4000_0000_0000_0000, 3'b001});
        send(0, 11'd1023, 11'd1023, tie, 2'b00, {64'h3FFF_FFFF_FFFF_FFFE, 3'b001});
        send(0, 11'd2046, 11'd2046, one, 2'b00, {64'h7FF0_0000_0000_0000, 3'b101});
        send(1, 11'd1, 11'd1, one, 2'b00, {64'h8000_0000_0000_0000, 3'b011});
        send(1, 11'd77, 11'd5, carry, 2'b11, {64'h7FF8_0000_0000_0000, 3'b000});
        send(1, 11'd0, 11'd0, '0, 2'b10, {64'hFFF0_0000_0000_0000, 3'b000});
        send(1, 11'd900, 11'd900, one, 2'b01, {64'h8000_0000_0000_0000, 3'b000});
        send(0, 11'd2046, 11'd1023, carry, 2'b00, {64'h7FF0_0000_0000_0000, 3'b101});
        send(0, 11'd1, 11'd1023, one, 2'b00, {64'h0010_0000_0000_0000, 3'b000});
        send(0, 11'd1, 11'd1022, one, 2'b00, {64'h0000_0000_0000_0000, 3'b011});
        send(0, 11'd1023, 11'd1023, one | 106'd1, 2'b00,
             {64'h3FF0_0000_0000_0000, 3'b001});
        send(0, 11'd1023, 11'd1023,
             (106'd1 << 105) | (106'd1 << 53) | (106'd1 << 52), 2'b00,
             {64'h4000_0000_0000_0002, 3'b001});
        drain();

        tog_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [52:0]  ma;
            logic [52:0]  mb;
            logic [105:0] p;
            logic [10:0]  ea;
            logic [10:0]  eb;
            logic [1:0]   c;
            ma = {1'b1, 20'($urandom), 32'($urandom)};
            mb = {1'b1, 20'($urandom), 32'($urandom)};
            p  = {53'd0, ma} * {53'd0, mb};
            if (k % 2 == 0) begin
                ea = 11'($urandom_range(1, 2046));
                eb = 11'($urandom_range(1, 2046));
            end else begin
                ea = 11'($urandom_range(400, 1646));
                eb = 11'($urandom_range(400, 1646));
            end
            c = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sendm(1'($urandom), ea, eb, p, c);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        tog_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    sendm(0, 11'd1023, 11'(1023 + i), one, 2'b00);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", exp_t'(in_ready), exp_t'(0));
                chk("bp_out_valid", exp_t'(out_valid), exp_t'(1));
                held = {out_result, out_overflow, out_underflow, out_inexact};
                chk("bp_first_beat", held, {64'h3FF0_0000_0000_0000, 3'b000});
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_stable",
                        {out_result, out_overflow, out_underflow, out_inexact}, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++)
            sendm(0, 11'd1000, 11'(1030 + i), carry, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", exp_t'(out_valid), exp_t'(0));
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_flush", exp_t'(out_valid), exp_t'(0));
        end
        chk("rst_mid_in_ready", exp_t'(in_ready), exp_t'(1));
        @(posedge clk);
        #1;
        send(0, 11'd1023, 11'd1023, one, 2'b00, {64'h3FF0_0000_0000_0000, 3'b000});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
